// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU execute stage.
// Single-cycle ops (add/addu/sub/subu/and/or/xor/nor/slt/sltu) complete one
// cycle after acceptance. CLO/CLZ walk the operand bit-serially from bit 31.
// Optional feature macro: ALU_OVERFLOW_EN enables the signed-overflow flag
// for add/sub. When it is undefined the ovf port is tied low.
module alu_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        err,
  output logic        ovf
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned CW = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_CLO  = 6'b111000;
  localparam logic [5:0] F_CLZ  = 6'b000111;

  logic [1:0]    state;
  logic [1:0]    state_next;

  // Bit-serial counter context, captured on the accepting edge.
  logic [DW-1:0] src_q;
  logic [DW-1:0] src_next;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic          clo_q;
  logic          clo_next;

  logic          ready_next;
  logic          done_next;
  logic [DW-1:0] result_next;
  logic          zero_next;
  logic          err_next;
  logic          ovf_next;

  // Single-cycle datapath outputs (driven straight from the inputs, so the
  // value registered on the accepting edge is the captured operation).
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] alu_res;
  logic          alu_err;
  logic          alu_ovf;
  logic          is_count;

  // Count-step signals
  logic          cur_bit;
  logic          hit;
  logic          last_step;
  logic [CW-1:0] cnt_inc;

  // Combinational ALU for the single-cycle function codes
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_err = 1'b0;
    alu_ovf = 1'b0;
    case (func)
      F_ADD: begin
        alu_res = sum;
`ifdef ALU_OVERFLOW_EN
        alu_ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
`endif
      end
      F_ADDU: alu_res = sum;
      F_SUB: begin
        alu_res = diff;
`ifdef ALU_OVERFLOW_EN
        alu_ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
`endif
      end
      F_SUBU: alu_res = diff;
      F_AND:  alu_res = a & b;
      F_OR:   alu_res = a | b;
      F_XOR:  alu_res = a ^ b;
      F_NOR:  alu_res = ~(a | b);
      F_SLT:  alu_res = {31'd0, ($signed(a) < $signed(b))};
      F_SLTU: alu_res = {31'd0, (a < b)};
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // Decode of the bit-serial count functions
  always_comb begin
    is_count = (func == F_CLO) || (func == F_CLZ);
  end

  // One step of the leading-ones/zeros scan
  always_comb begin
    cur_bit   = src_q[idx_q];
    hit       = (cur_bit == clo_q);
    cnt_inc   = cnt_q + CW'(hit);
    last_step = !hit || (idx_q == IW'(0));
  end

  // Next-state and next-output logic
  always_comb begin
    state_next  = state;
    src_next    = src_q;
    idx_next    = idx_q;
    cnt_next    = cnt_q;
    clo_next    = clo_q;
    done_next   = 1'b0;
    err_next    = 1'b0;
    ovf_next    = 1'b0;
    result_next = result;
    zero_next   = zero;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_count) begin
            state_next = S_COUNT;
            src_next   = a;
            idx_next   = IW'(DW - 1);
            cnt_next   = '0;
            clo_next   = (func == F_CLO);
          end else begin
            state_next  = S_DONE;
            done_next   = 1'b1;
            result_next = alu_res;
            zero_next   = (alu_res == '0);
            err_next    = alu_err;
            ovf_next    = alu_ovf;
          end
        end
      end

      S_COUNT: begin
        cnt_next = cnt_inc;
        if (last_step) begin
          state_next  = S_DONE;
          done_next   = 1'b1;
          result_next = DW'(cnt_inc);
          zero_next   = (cnt_inc == '0);
        end else begin
          idx_next = idx_q - IW'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    ready_next = (state_next == S_IDLE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      src_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      clo_q  <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_next;
      src_q  <= src_next;
      idx_q  <= idx_next;
      cnt_q  <= cnt_next;
      clo_q  <= clo_next;
      ready  <= ready_next;
      done   <= done_next;
      result <= result_next;
      zero   <= zero_next;
      err    <= err_next;
      ovf    <= ovf_next;
    end
  end

endmodule
